philo_ring: RTL and testbench

Parametrised ring of N dining-philosopher state machines with per-philosopher hunger aging and built-in safety monitors. It is the synthesizable successor of the fixed 16-philosopher ring: nondeterministic choices are explicit `coin` inputs, the ring has a real reset, and the block adds a stall input, starvation detection and an adjacent-eaters error flag. It sits at the top of the philosopher model as the design under property checking and simulation.

---
 rtl/philo_ring_if.sv | 22 ++
 rtl/philo_ring.sv | 108 ++++++++++
 tb/tb_philo_ring.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/philo_ring_if.sv
// philo_ring_if: control and status bundle of the philosopher ring.
// The master drives step/coin; the slave reports states and monitor flags.
interface philo_ring_if #(
    parameter int N = 16
);
    logic           step;
    logic [N-1:0]   coin;
    logic [2*N-1:0] st;
    logic [N-1:0]   starve;
    logic [N-1:0]   starve_seen;
    logic           mutex_err;

    modport master (
        output step, coin,
        input  st, starve, starve_seen, mutex_err
    );

    modport slave (
        input  step, coin,
        output st, starve, starve_seen, mutex_err
    );
endinterface

// File: rtl/philo_ring.sv
// philo_ring: ring of N dining-philosopher FSMs with hunger aging and monitors.
// Optional macro PHILO_AGING_EN lets starvation feed back into arbitration.
module philo_ring #(
    parameter int N            = 16,
    parameter int INIT_READER  = 0,
    parameter int STARVE_LIMIT = 15
) (
    input  logic         clock,
    input  logic         reset_n,
    philo_ring_if.slave  bus
);
    typedef enum logic [1:0] {
        THINKING = 2'd0,
        READING  = 2'd1,
        EATING   = 2'd2,
        HUNGRY   = 2'd3
    } ph_t;

    localparam int HW = $clog2(STARVE_LIMIT + 1);
    localparam logic [HW-1:0] LIM = HW'(STARVE_LIMIT);

    logic [N-1:0][1:0] stq;
    logic [N-1:0]      stv;
    logic [N-1:0]      ee;
    logic              mx;

    for (genvar i = 0; i < N; i++) begin : g_ph
        localparam int L = (i + 1) % N;
        localparam int R = (i + N - 1) % N;

        ph_t           s;
        ph_t           nx;
        logic [HW-1:0] hc;
        logic [HW-1:0] hn;
        logic          seen;
        logic          sn;
        logic          go;

        // Next state, hunger count and sticky flag from last-cycle ring states
        always_comb begin
            nx = s;
            hn = hc;
            sn = seen;
            go = 1'b0;
            if (bus.step) begin
                unique case (s)
                    READING: begin
                        if (stq[L] == THINKING) nx = THINKING;
                    end
                    THINKING: begin
                        if (!bus.coin[i]) nx = HUNGRY;
                        else if (stq[R] == READING) nx = READING;
                    end
                    EATING: begin
`ifdef PHILO_AGING_EN
                        if (bus.coin[i] || stv[L] || stv[R]) nx = THINKING;
`else
                        if (bus.coin[i]) nx = THINKING;
`endif
                    end
                    HUNGRY: begin
                        go = (stq[L] != EATING) &&
                             (stq[R] != HUNGRY) &&
                             (stq[R] != EATING);
`ifdef PHILO_AGING_EN
                        go = go && (stv[i] || !(stv[L] || stv[R]));
`endif
                        if (go) nx = EATING;
                    end
                endcase
                if (nx == HUNGRY && s == HUNGRY)
                    hn = (hc == LIM) ? LIM : hc + HW'(1);
                else
                    hn = '0;
                sn = seen | (hn == LIM);
            end
        end

        // Per-philosopher state register
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                if (i == INIT_READER) s <= READING;
                else s <= THINKING;
                hc   <= '0;
                seen <= 1'b0;
            end else begin
                s    <= nx;
                hc   <= hn;
                seen <= sn;
            end
        end

        assign stq[i]             = s;
        assign stv[i]             = (hc == LIM);
        assign ee[i]              = (s == EATING) && (stq[L] == EATING);
        assign bus.st[2*i +: 2]   = s;
        assign bus.starve[i]      = stv[i];
        assign bus.starve_seen[i] = seen;
    end

    // Sticky adjacent-eaters monitor, sampled every clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) mx <= 1'b0;
        else mx <= mx | (|ee);
    end

    assign bus.mutex_err = mx;
endmodule

// File: tb/tb_philo_ring.sv
// tb_philo_ring: scoreboard bench for philo_ring (N=16, N=4 and N=5 rings).
// Expected responses are queued by the driver and popped by a negedge monitor.
module tb_philo_ring;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;
    bit   rnd_on = 1'b0;

    philo_ring_if #(.N(16)) b16 ();
    philo_ring_if #(.N(4))  b4 ();
    philo_ring_if #(.N(5))  b5 ();

    philo_ring #(.N(16), .INIT_READER(0), .STARVE_LIMIT(15)) u16 (
        .clock(clk), .reset_n(rst_n), .bus(b16));
    philo_ring #(.N(4), .INIT_READER(0), .STARVE_LIMIT(3)) u4 (
        .clock(clk), .reset_n(rst_n), .bus(b4));
    philo_ring #(.N(5), .INIT_READER(0), .STARVE_LIMIT(4)) u5 (
        .clock(clk), .reset_n(rst_n), .bus(b5));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          unit;
        logic [31:0] st;
        logic [15:0] sv;
        logic [15:0] ss;
        logic        me;
        string       nm;
    } exp_t;

    exp_t q[$];

    task automatic cmp(input exp_t e);
        logic [31:0] ast;
        logic [15:0] asv;
        logic [15:0] ass;
        logic        ame;
        case (e.unit)
            16: begin
                ast = b16.st; asv = b16.starve;
                ass = b16.starve_seen; ame = b16.mutex_err;
            end
            4: begin
                ast = 32'(b4.st); asv = 16'(b4.starve);
                ass = 16'(b4.starve_seen); ame = b4.mutex_err;
            end
            default: begin
                ast = 32'(b5.st); asv = 16'(b5.starve);
                ass = 16'(b5.starve_seen); ame = b5.mutex_err;
            end
        endcase
        checks++;
        if (ast !== e.st || asv !== e.sv || ass !== e.ss || ame !== e.me) begin
            errors++;
            $display("FAIL %s: got st=%h starve=%h seen=%h mutex=%b, want st=%h starve=%h seen=%h mutex=%b",
                     e.nm, ast, asv, ass, ame, e.st, e.sv, e.ss, e.me);
        end
    endtask

    task automatic chk1(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            cmp(e);
        end
    end

    // Independent safety watch on the random ring
    always @(negedge clk) begin
        if (rnd_on) begin
            for (int j = 0; j < 5; j++) begin
                if (b5.st[2*j +: 2] == 2'd2 && b5.st[2*((j+1)%5) +: 2] == 2'd2)
                    viol++;
            end
        end
    end

    task automatic drv(input int unit, input logic stp, input logic [15:0] cn,
                       input logic [31:0] est, input logic [15:0] esv,
                       input logic [15:0] ess, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (unit == 16) begin
            b16.step = stp; b16.coin = cn;
        end else if (unit == 4) begin
            b4.step = stp; b4.coin = cn[3:0];
        end else begin
            b5.step = stp; b5.coin = cn[4:0];
        end
        e.due = cyc + 1; e.unit = unit; e.st = est;
        e.sv = esv; e.ss = ess; e.me = 1'b0; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    function automatic exp_t mk(input int unit, input logic [31:0] est,
                                input string nm);
        exp_t e;
        e.due = 0; e.unit = unit; e.st = est;
        e.sv = '0; e.ss = '0; e.me = 1'b0; e.nm = nm;
        return e;
    endfunction

`ifdef PHILO_AGING_EN
    logic [7:0] st4 [7] = '{8'hFC, 8'hFB, 8'hFB, 8'hFB, 8'hF3, 8'hEF, 8'hCF};
    logic [3:0] sv4 [7] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'hD, 4'h9, 4'h9};
`else
    logic [7:0] st4 [7] = '{8'hFC, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB};
    logic [3:0] sv4 [7] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'hD, 4'hD, 4'hD};
`endif
    logic [3:0] ss4 [7] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'hD, 4'hD, 4'hD};

    initial begin
        logic [31:0] pos;
        rst_n = 1'b1;
        b16.step = 1'b0; b16.coin = '0;
        b4.step = 1'b0;  b4.coin = '0;
        b5.step = 1'b0;  b5.coin = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp(mk(16, 32'h0000_0001, "reset16"));
        cmp(mk(4, 32'h01, "reset4"));
        cmp(mk(5, 32'h001, "reset5"));
        rst_n = 1'b1;

        for (int k = 1; k <= 7; k++)
            drv(16, 1'b1, 16'hFFFF, 32'd1 << (2*k), '0, '0, $sformatf("rot%0d", k));
        for (int k = 0; k < 5; k++)
            drv(16, 1'b0, 16'($urandom), 32'd1 << 14, '0, '0, $sformatf("stall%0d", k));
        for (int k = 8; k <= 19; k++)
            drv(16, 1'b1, 16'hFFFF, 32'd1 << (2*(k%16)), '0, '0, $sformatf("rot%0d", k));
        drv(16, 1'b0, 16'hFFFF, 32'd1 << 6, '0, '0, "rot_hold");
        drain();

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        cmp(mk(16, 32'h0000_0001, "async_reset16"));
        cmp(mk(4, 32'h01, "async_reset4"));
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 7; k++)
            drv(4, 1'b1, 16'h0, 32'(st4[k]), 16'(sv4[k]), 16'(ss4[k]),
                $sformatf("starve_e%0d", k + 1));
        pos = 32'(st4[6]);
        for (int k = 0; k < 3; k++)
            drv(4, 1'b0, 16'($urandom), pos, 16'(sv4[6]), 16'(ss4[6]),
                $sformatf("starve_stall%0d", k));
        drain();

        rnd_on = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk);
            #1;
            b5.step = 1'($urandom_range(0, 1));
            b5.coin = 5'($urandom);
        end
        b5.step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rnd_on = 1'b0;
        chk1("rand_mutex_err", int'(b5.mutex_err), 0);
        chk1("rand_adjacent_eaters", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
